// File: rtl/id_ex_if.sv
// Handshake and decoded-bundle signals between fetch, the ID/EX register and execute.
interface id_ex_if #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5,
  parameter int PC_WIDTH      = 64
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_inst;
  logic [PC_WIDTH-1:0]      in_pc;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [ALU_CTRL_BITS-1:0] out_alu_ctrl;
  logic [REG_WIDTH-1:0]     out_imm;
  logic [4:0]               out_rs1_idx;
  logic [4:0]               out_rs2_idx;
  logic [4:0]               out_rd_idx;
  logic                     out_reg_write;
  logic                     out_op1_pc;
  logic                     out_is_jal;
  logic                     out_illegal;
  logic [PC_WIDTH-1:0]      out_pc;

  // Decode/register side.
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_alu_ctrl, out_imm, out_rs1_idx, out_rs2_idx,
           out_rd_idx, out_reg_write, out_op1_pc, out_is_jal, out_illegal, out_pc
  );

  // Fetch/execute side.
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_alu_ctrl, out_imm, out_rs1_idx, out_rs2_idx,
           out_rd_idx, out_reg_write, out_op1_pc, out_is_jal, out_illegal, out_pc
  );
endinterface

// File: rtl/id_ex_decode.sv
// RV64 decode (OP, OP-IMM, LUI, JAL) feeding a single-entry valid/ready ID/EX register.
module id_ex_decode #(
  parameter int REG_WIDTH     = 64,
  parameter int ALU_CTRL_BITS = 5,
  parameter int PC_WIDTH      = 64
) (
  input  logic   clk,
  input  logic   rst,
  id_ex_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [31:0]              inst;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [ALU_CTRL_BITS-1:0] d_alu;
  logic [REG_WIDTH-1:0]     d_imm;
  logic [4:0]               d_rs1;
  logic [4:0]               d_rs2;
  logic [4:0]               d_rd;
  logic                     d_legal;
  logic                     d_jal;
  logic                     d_reg_write;
  logic                     capture;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Ready whenever the slot is empty or is being consumed this cycle; flush does not gate it.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  // Combinational decode of the incoming word; illegal encodings collapse to a neutral bundle.
  always_comb begin
    d_alu   = '0;
    d_imm   = '0;
    d_rs1   = inst[19:15];
    d_rs2   = '0;
    d_rd    = inst[11:7];
    d_legal = 1'b1;
    d_jal   = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        d_rs2 = inst[24:20];
        case (funct3)
          3'b000: if (funct7 == 7'b0000000) d_alu = 5'b00000;
                  else if (funct7 == 7'b0100000) d_alu = 5'b00001;
                  else d_legal = 1'b0;
          3'b001: if (funct7 == 7'b0000000) d_alu = 5'b00101; else d_legal = 1'b0;
          3'b010: if (funct7 == 7'b0000000) d_alu = 5'b01000; else d_legal = 1'b0;
          3'b011: if (funct7 == 7'b0000000) d_alu = 5'b01001; else d_legal = 1'b0;
          3'b100: if (funct7 == 7'b0000000) d_alu = 5'b00010; else d_legal = 1'b0;
          3'b101: if (funct7 == 7'b0000000) d_alu = 5'b00110;
                  else if (funct7 == 7'b0100000) d_alu = 5'b00111;
                  else d_legal = 1'b0;
          3'b110: if (funct7 == 7'b0000000) d_alu = 5'b00011; else d_legal = 1'b0;
          default: if (funct7 == 7'b0000000) d_alu = 5'b00100; else d_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        d_imm = {{(REG_WIDTH-12){inst[31]}}, inst[31:20]};
        case (funct3)
          3'b000: d_alu = 5'b10000;
          3'b010: d_alu = 5'b10111;
          3'b011: d_alu = 5'b11000;
          3'b100: d_alu = 5'b10001;
          3'b110: d_alu = 5'b10010;
          3'b111: d_alu = 5'b10011;
          3'b001: begin
            d_imm = {{(REG_WIDTH-6){1'b0}}, inst[25:20]};
            if (inst[31:26] == 6'b000000) d_alu = 5'b10100; else d_legal = 1'b0;
          end
          default: begin
            d_imm = {{(REG_WIDTH-6){1'b0}}, inst[25:20]};
            if (inst[31:26] == 6'b000000) d_alu = 5'b10101;
            else if (inst[31:26] == 6'b010000) d_alu = 5'b10110;
            else d_legal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        d_alu = 5'b11111;
        d_rs1 = '0;
        d_imm = {{(REG_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        d_alu = 5'b11110;
        d_rs1 = '0;
        d_jal = 1'b1;
        d_imm = {{(REG_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_alu = '0;
      d_imm = '0;
    end
  end

  assign d_reg_write = d_legal && (d_rd != 5'd0);

  // ID/EX register: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_alu_ctrl  <= '0;
      bus.out_imm       <= '0;
      bus.out_rs1_idx   <= '0;
      bus.out_rs2_idx   <= '0;
      bus.out_rd_idx    <= '0;
      bus.out_reg_write <= 1'b0;
      bus.out_op1_pc    <= 1'b0;
      bus.out_is_jal    <= 1'b0;
      bus.out_illegal   <= 1'b0;
      bus.out_pc        <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid     <= 1'b1;
      bus.out_alu_ctrl  <= d_alu;
      bus.out_imm       <= d_imm;
      bus.out_rs1_idx   <= d_rs1;
      bus.out_rs2_idx   <= d_rs2;
      bus.out_rd_idx    <= d_rd;
      bus.out_reg_write <= d_reg_write;
      bus.out_op1_pc    <= d_jal;
      bus.out_is_jal    <= d_jal;
      bus.out_illegal   <= !d_legal;
      bus.out_pc        <= bus.in_pc;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode: decode table, backpressure, streaming, flush and reset.
module tb_id_ex_decode;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  id_ex_if bus ();

  id_ex_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {valid, alu, imm, rs1, rs2, rd, reg_write, op1_pc, is_jal, illegal}
  function automatic logic [88:0] got();
    return {bus.out_valid, bus.out_alu_ctrl, bus.out_imm, bus.out_rs1_idx, bus.out_rs2_idx,
            bus.out_rd_idx, bus.out_reg_write, bus.out_op1_pc, bus.out_is_jal, bus.out_illegal};
  endfunction

  function automatic logic [88:0] bdl(input logic [4:0] alu, input logic [63:0] imm,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic rw, input logic jal,
                                      input logic ill);
    return {1'b1, alu, imm, rs1, rs2, rd, rw, jal, jal, ill};
  endfunction

  // One instruction through an idle register with execute always ready.
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (got() !== 89'd0 || bus.out_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got %h pc %h, want 0", got(), bus.out_pc);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_op();
    logic [31:0] ins [5];
    logic [88:0] exp [5];
    ins[0] = 32'h002081B3; exp[0] = bdl(5'b00000, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    ins[1] = 32'h402081B3; exp[1] = bdl(5'b00001, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    ins[2] = 32'h0020C1B3; exp[2] = bdl(5'b00010, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    ins[3] = 32'h0020B1B3; exp[3] = bdl(5'b01001, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    ins[4] = 32'h00000033; exp[4] = bdl(5'b00000, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(ins[i], 64'h100 + 64'(i * 4));
      checks++;
      if (got() !== exp[i]) begin
        errors++;
        $display("FAIL op[%0d] %h: got %h want %h", i, ins[i], got(), exp[i]);
      end
    end
  endtask

  task automatic test_op_imm();
    logic [31:0] ins [4];
    logic [88:0] exp [4];
    ins[0] = 32'h43F35293; exp[0] = bdl(5'b10110, 64'd63, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    ins[1] = 32'hFFF00093; exp[1] = bdl(5'b10000, 64'hFFFFFFFFFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    ins[2] = 32'hFF01F213; exp[2] = bdl(5'b10011, 64'hFFFFFFFFFFFFFFF0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    ins[3] = 32'h02009093; exp[3] = bdl(5'b10100, 64'd32, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(ins[i], 64'h200);
      checks++;
      if (got() !== exp[i]) begin
        errors++;
        $display("FAIL op_imm[%0d] %h: got %h want %h", i, ins[i], got(), exp[i]);
      end
    end
  endtask

  task automatic test_lui_jal();
    send(32'h800003B7, 64'h0);
    checks++;
    if (got() !== bdl(5'b11111, 64'hFFFFFFFF80000000, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL lui: got %h", got());
    end
    send(32'h008000EF, 64'h1000);
    checks++;
    if (got() !== bdl(5'b11110, 64'd8, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL jal: got %h", got());
    end
    checks++;
    if (bus.out_pc !== 64'h1000) begin
      errors++;
      $display("FAIL jal_pc: got %h want 1000", bus.out_pc);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [4];
    logic [88:0] exp [4];
    ins[0] = 32'h402091B3; exp[0] = bdl(5'b00000, 64'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    ins[1] = 32'h00000073; exp[1] = bdl(5'b00000, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    ins[2] = 32'h022081B3; exp[2] = bdl(5'b00000, 64'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    ins[3] = 32'h40009093; exp[3] = bdl(5'b00000, 64'd0, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(ins[i], 64'h300);
      checks++;
      if (got() !== exp[i]) begin
        errors++;
        $display("FAIL illegal[%0d] %h: got %h want %h", i, ins[i], got(), exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [88:0] add_exp;
    add_exp = bdl(5'b00000, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = 32'h002081B3; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_inst = 32'hFFF00093;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || got() !== add_exp) begin
        errors++;
        $display("FAIL hold[%0d]: in_ready %b bundle %h want 0 %h", c, bus.in_ready, got(), add_exp);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_inst = (32'(k) << 20) | (32'd1 << 7) | 32'h13;
      @(negedge clk);
      checks++;
      if (got() !== bdl(5'b10000, 64'(k), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL stream[%0d]: got %h", k, got());
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = 32'h002081B3; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_inst = 32'hFFF00093; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: valid %b in_ready %b want 1 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: out_valid %b want 0", bus.out_valid);
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = 32'h002081B3; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_valid %b want 0", bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_op();
    test_op_imm();
    test_lui_jal();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
